// File: rtl/quad_step_decoder.sv
// -----------------------------------------------------------------------------
// quad_step_decoder
//
// Front end for an up/down counter. Two asynchronous quadrature channels (A/B)
// are synchronised, optionally glitch-filtered, and decoded into a one-cycle
// step pulse plus a direction level. Double-edge transitions (both channels
// moving at once) are flagged and counted in a saturating error counter.
//
// Optional feature macro: QUAD_GLITCH_FILTER_EN
//   defined   - each channel has a 4-bit run counter. A new level must be seen
//               FILT_LEN consecutive cycles before it reaches the decoder.
//   undefined - the synchronised levels feed the decoder directly and
//               FILT_LEN has no effect.
//
// Parameters:
//   FILT_LEN  qualification length of the glitch filter (2..15)
//   ERR_W     width of the error counter
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   a_in     in   quadrature channel A (asynchronous)
//   b_in     in   quadrature channel B (asynchronous)
//   clr_err  in   synchronous clear of err_cnt (wins over a same-cycle error)
//   step     out  one-cycle pulse per accepted legal edge
//   mode     out  direction of the last step, 1 = up, 0 = down
//   err      out  one-cycle pulse per illegal transition
//   err_cnt  out  saturating count of illegal transitions
// -----------------------------------------------------------------------------
module quad_step_decoder #(
   parameter int FILT_LEN = 3,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_in,
   input  logic             b_in,
   input  logic             clr_err,
   output logic             step,
   output logic             mode,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt
);

   // Three priming states load prev without decoding, then RUN until reset.
   typedef enum logic [1:0] {
      ST_PRIME0,
      ST_PRIME1,
      ST_PRIME2,
      ST_RUN
   } state_t;

   state_t           state_reg, state_next;

   // Channel vectors are packed as {A, B}.
   logic [1:0]       sync0_reg;
   logic [1:0]       sync1_reg;
   logic [1:0]       chan_s;
   logic [1:0]       chan_f;
   logic [1:0]       prev_reg;
   logic             priming;

   logic             step_reg, step_next;
   logic             err_reg, err_next;
   logic             mode_reg, mode_next;
   logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;

   if (FILT_LEN < 2 || FILT_LEN > 15) begin : g_bad_filt_len
      $error("quad_step_decoder: FILT_LEN must lie in 2..15");
   end

   // -------------------------------------------------------------------------
   // Two-flop synchronisers for both channels
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync0_reg <= 2'b00;
         sync1_reg <= 2'b00;
      end else begin
         sync0_reg <= {a_in, b_in};
         sync1_reg <= sync0_reg;
      end
   end

   assign chan_s  = sync1_reg;
   assign priming = (state_reg != ST_RUN);

   // -------------------------------------------------------------------------
   // Accepted levels
   // -------------------------------------------------------------------------
`ifdef QUAD_GLITCH_FILTER_EN
   // The counter value is the number of consecutive mismatching samples seen
   // so far; the sample that would make it reach FILT_LEN commits the level.
   localparam logic [3:0] RUN_LAST = 4'(FILT_LEN - 1);

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_filt
      logic [3:0] run_reg;
      logic       hold_reg;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            run_reg  <= 4'd0;
            hold_reg <= 1'b0;
         end else if (priming) begin
            // Track the input so RUN starts from the primed level.
            run_reg  <= 4'd0;
            hold_reg <= chan_s[gi];
         end else if (chan_s[gi] == hold_reg) begin
            run_reg  <= 4'd0;
         end else if (run_reg == RUN_LAST) begin
            run_reg  <= 4'd0;
            hold_reg <= chan_s[gi];
         end else begin
            run_reg  <= run_reg + 4'd1;
         end
      end

      assign chan_f[gi] = priming ? chan_s[gi] : hold_reg;
   end
`else
   assign chan_f = chan_s;
`endif

   // -------------------------------------------------------------------------
   // Priming sequencer and quadrature decode
   // -------------------------------------------------------------------------
   always_comb begin
      state_next   = state_reg;
      step_next    = 1'b0;
      err_next     = 1'b0;
      mode_next    = mode_reg;
      err_cnt_next = err_cnt_reg;

      case (state_reg)
         ST_PRIME0: state_next = ST_PRIME1;
         ST_PRIME1: state_next = ST_PRIME2;
         ST_PRIME2: state_next = ST_RUN;
         default: begin
            case ({prev_reg, chan_f})
               // A leads B: 00 -> 10 -> 11 -> 01 -> 00
               4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
                  step_next = 1'b1;
                  mode_next = 1'b1;
               end
               // B leads A: 00 -> 01 -> 11 -> 10 -> 00
               4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
                  step_next = 1'b1;
                  mode_next = 1'b0;
               end
               // Both channels moved in one sample: direction is unknowable.
               4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: begin
                  err_next = 1'b1;
                  if (err_cnt_reg != {ERR_W{1'b1}}) begin
                     err_cnt_next = err_cnt_reg + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      endcase

      // Clear takes priority over a simultaneous increment; err still pulses.
      if (clr_err) begin
         err_cnt_next = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= ST_PRIME0;
         prev_reg    <= 2'b00;
         step_reg    <= 1'b0;
         err_reg     <= 1'b0;
         mode_reg    <= 1'b1;
         err_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         prev_reg    <= chan_f;
         step_reg    <= step_next;
         err_reg     <= err_next;
         mode_reg    <= mode_next;
         err_cnt_reg <= err_cnt_next;
      end
   end

   assign step    = step_reg;
   assign err     = err_reg;
   assign mode    = mode_reg;
   assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_quad_step_decoder.sv
// -----------------------------------------------------------------------------
// tb_quad_step_decoder
//
// Directed sections (reset, up, down/reversal, illegal, clear, saturation and,
// when QUAD_GLITCH_FILTER_EN is defined, the glitch filter) followed by random
// A/B activity. Every cycle the outputs are compared against a reference
// model that works from the history of sampled inputs: positions on the
// quadrature cycle, modular differences and a sliding qualification window.
// -----------------------------------------------------------------------------
module tb_quad_step_decoder;

   localparam int ERR_W   = 2;
   localparam int FL      = 3;
   localparam int ERR_MAX = (1 << ERR_W) - 1;
`ifdef QUAD_GLITCH_FILTER_EN
   localparam int LAT = 3 + FL;
`else
   localparam int LAT = 3;
`endif

   logic             clk;
   logic             rst;
   logic             a_in;
   logic             b_in;
   logic             clr_err;
   logic             step;
   logic             mode;
   logic             err;
   logic [ERR_W-1:0] err_cnt;

   quad_step_decoder #(
      .FILT_LEN (FL),
      .ERR_W    (ERR_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .a_in    (a_in),
      .b_in    (b_in),
      .clr_err (clr_err),
      .step    (step),
      .mode    (mode),
      .err     (err),
      .err_cnt (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Position of each {A,B} code on the up-counting cycle 00,10,11,01.
   int pos_tab [4] = '{0, 3, 1, 2};

   // Model state: histories indexed by edge number since reset release.
   bit [1:0] in_hist[$];
   bit [1:0] s_hist[$];
   bit [1:0] f_hist[$];
   int       n;
   bit [1:0] m_prev;
   bit       m_step, m_err, m_mode;
   int       m_cnt;

   int step_seen = 0;
   int err_seen  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, n);
      end
   endtask

   task automatic model_reset();
      in_hist.delete();
      s_hist.delete();
      f_hist.delete();
      n      = 0;
      m_prev = 2'b00;
      m_step = 1'b0;
      m_err  = 1'b0;
      m_mode = 1'b1;
      m_cnt  = 0;
   endtask

   // Advance the model by one clock edge, given the inputs sampled on it.
   task automatic model_edge(input bit [1:0] ab, input bit clr);
      bit [1:0] s_now;
      bit [1:0] cur;
      bit [1:0] f_new;
      int       d;
      in_hist.push_back(ab);
      // Synchronised level = input sampled two edges earlier.
      s_now = (n >= 2) ? in_hist[n-2] : 2'b00;
      s_hist.push_back(s_now);
      if (n == 0) f_hist.push_back(2'b00);
`ifdef QUAD_GLITCH_FILTER_EN
      cur = (n < 3) ? s_now : f_hist[n];
      if (n < 3) begin
         f_new = s_now;
      end else begin
         f_new = f_hist[n];
         for (int b = 0; b < 2; b++) begin
            bit ok;
            ok = (n - FL + 1 >= 3);
            for (int k = 0; k < FL; k++) begin
               if (ok && s_hist[n-k][b] == f_hist[n][b]) ok = 1'b0;
            end
            if (ok) f_new[b] = s_now[b];
         end
      end
`else
      cur   = s_now;
      f_new = s_now;
`endif
      f_hist.push_back(f_new);

      m_step = 1'b0;
      m_err  = 1'b0;
      if (n >= 3) begin
         d = (pos_tab[cur] - pos_tab[m_prev] + 4) % 4;
         if (d == 1) begin
            m_step = 1'b1;
            m_mode = 1'b1;
         end else if (d == 3) begin
            m_step = 1'b1;
            m_mode = 1'b0;
         end else if (d == 2) begin
            m_err = 1'b1;
            if (m_cnt < ERR_MAX) m_cnt++;
         end
      end
      if (clr) m_cnt = 0;
      m_prev = cur;
      n++;
   endtask

   // One clock: sample, update model, compare all outputs 1 ns later.
   task automatic tick();
      @(posedge clk);
      model_edge({a_in, b_in}, clr_err);
      #1;
      chk("step", 32'(step), 32'(m_step));
      chk("err", 32'(err), 32'(m_err));
      chk("mode", 32'(mode), 32'(m_mode));
      chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
      step_seen += int'(step);
      err_seen  += int'(err);
      $display("edge %0d ab=%b clr=%b -> step=%b mode=%b err=%b err_cnt=%0d",
               n - 1, {a_in, b_in}, clr_err, step, mode, err, err_cnt);
   endtask

   task automatic do_reset(input bit [1:0] ab);
      rst     = 1'b1;
      {a_in, b_in} = ab;
      clr_err = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_step", 32'(step), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_mode", 32'(mode), 32'd1);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic hold(input bit [1:0] ab, input int cycles);
      {a_in, b_in} = ab;
      repeat (cycles) tick();
   endtask

   // Drive a legal move and measure the clocks until its step pulse.
   task automatic move_lat(input bit [1:0] ab, input int cycles, input string tag);
      int seen_at;
      seen_at = -1;
      {a_in, b_in} = ab;
      for (int i = 1; i <= cycles; i++) begin
         tick();
         if (step === 1'b1 && seen_at < 0) seen_at = i;
      end
      chk(tag, 32'(seen_at), 32'(LAT));
   endtask

   int s0, e0;

   initial begin
      rst = 1'b1;
      a_in = 1'b0;
      b_in = 1'b0;
      clr_err = 1'b0;
      model_reset();

      // Reset state with inputs at 11: priming must not report an error.
      do_reset(2'b11);
      s0 = step_seen; e0 = err_seen;
      hold(2'b11, 20);
      chk("prime_no_err", 32'(err_seen - e0), 32'd0);
      chk("prime_no_step", 32'(step_seen - s0), 32'd0);
      chk("prime_mode", 32'(mode), 32'd1);

      // Up sequence 00 -> 10 -> 11 -> 01 -> 00.
      do_reset(2'b00);
      hold(2'b00, 10);
      s0 = step_seen;
      move_lat(2'b10, 10, "up_lat_10");
      move_lat(2'b11, 10, "up_lat_11");
      move_lat(2'b01, 10, "up_lat_01");
      move_lat(2'b00, 10, "up_lat_00");
      chk("up_steps", 32'(step_seen - s0), 32'd4);
      chk("up_mode", 32'(mode), 32'd1);

      // Down then reversal.
      s0 = step_seen;
      move_lat(2'b01, 10, "dn_lat_01");
      chk("dn_mode_1", 32'(mode), 32'd0);
      move_lat(2'b11, 10, "dn_lat_11");
      chk("dn_mode_2", 32'(mode), 32'd0);
      move_lat(2'b01, 10, "rev_lat_01");
      chk("rev_mode", 32'(mode), 32'd1);
      chk("dn_rev_steps", 32'(step_seen - s0), 32'd3);

      // Illegal transitions.
      do_reset(2'b00);
      hold(2'b00, 10);
      s0 = step_seen; e0 = err_seen;
      hold(2'b11, 10);
      hold(2'b00, 10);
      chk("ill_err_pulses", 32'(err_seen - e0), 32'd2);
      chk("ill_err_cnt", 32'(err_cnt), 32'd2);
      chk("ill_no_step", 32'(step_seen - s0), 32'd0);

      // Clear in the same cycle as a third error.
      {a_in, b_in} = 2'b11;
      repeat (LAT - 1) tick();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("clr_err_pulse", 32'(err), 32'd1);
      chk("clr_err_cnt", 32'(err_cnt), 32'd0);
      hold(2'b11, 8);

      // Saturation: five more illegal transitions into a 2-bit counter.
      e0 = err_seen;
      hold(2'b00, 8);
      hold(2'b11, 8);
      hold(2'b00, 8);
      hold(2'b11, 8);
      hold(2'b00, 8);
      chk("sat_err_pulses", 32'(err_seen - e0), 32'd5);
      chk("sat_err_cnt", 32'(err_cnt), 32'd3);

`ifdef QUAD_GLITCH_FILTER_EN
      // Short glitch on A is swallowed; a qualified change steps after 6.
      do_reset(2'b00);
      hold(2'b00, 10);
      s0 = step_seen;
      hold(2'b10, 2);
      hold(2'b00, 12);
      chk("glitch_no_step", 32'(step_seen - s0), 32'd0);
      move_lat(2'b10, 12, "filt_lat_10");
      hold(2'b00, 12);
      hold(2'b11, 12);
      chk("filt_mode_pre", 32'(mode), 32'd0);
      chk("filt_cnt_pre", 32'(err_cnt), 32'd1);

      // Reset in the middle of qualifying 11 -> 10.
      {a_in, b_in} = 2'b10;
      repeat (4) tick();
      rst = 1'b1;
      #1;
      chk("mid_rst_step", 32'(step), 32'd0);
      chk("mid_rst_err", 32'(err), 32'd0);
      chk("mid_rst_mode", 32'(mode), 32'd1);
      chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
      do_reset(2'b10);
      s0 = step_seen; e0 = err_seen;
      hold(2'b10, 15);
      chk("post_rst_no_step", 32'(step_seen - s0), 32'd0);
      chk("post_rst_no_err", 32'(err_seen - e0), 32'd0);
`endif

      // Random activity with occasional clears.
      do_reset(2'($urandom_range(0, 3)));
      for (int it = 0; it < 250; it++) begin
         {a_in, b_in} = 2'($urandom_range(0, 3));
         clr_err      = ($urandom_range(0, 15) == 0);
         repeat ($urandom_range(1, 6)) tick();
      end
      clr_err = 1'b0;
      hold({a_in, b_in}, 12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/quad_step_decoder.md
# quad_step_decoder

- Front-end stage that turns two asynchronous quadrature inputs (A/B from an encoder or manual jog) into a one-cycle `step` pulse plus a `mode` direction level.
- It sits directly upstream of the up/down counter: `mode` drives the counter's mode input (1 = up, 0 = down), and `step` gates the counter's clock enable.
- It also detects illegal double-edge transitions and keeps a saturating error count.

## Interface

Parameters:
- `FILT_LEN`, default 3. Consecutive-sample count a new input level must hold before it is accepted. Legal range 2..15. Used only when the filter is compiled in.
- `ERR_W`, default 8. Width of the error counter.

Ports:
- `clk` in 1 — single clock; all logic on rising edge.
- `rst` in 1 — asynchronous, active-high reset; clears all state.
- `a_in` in 1 — quadrature channel A, asynchronous to `clk`.
- `b_in` in 1 — quadrature channel B, asynchronous to `clk`.
- `clr_err` in 1 — synchronous clear of `err_cnt`.
- `step` out 1 — one-cycle pulse per accepted legal edge.
- `mode` out 1 — direction of the last step, 1 = up, 0 = down.
- `err` out 1 — one-cycle pulse per illegal transition.
- `err_cnt` out ERR_W — saturating count of illegal transitions.

## Operation

- **Synchronizer.** Each input passes through a 2-flop synchronizer: `a_in` → `a_s`, `b_in` → `b_s`.
- **Filter stage.** Produces the accepted levels `a_f` and `b_f` (see Configuration).
- **Priming.** For the first 3 cycles after reset release, the block is in priming:
  - `a_f`/`b_f` follow `a_s`/`b_s` directly.
  - The previous-state register `prev` = {a_f, b_f} is loaded every cycle.
  - `step` and `err` are forced to 0.
  - After priming, the block enters RUN and stays there until the next reset.
- **Decode in RUN**, comparing `cur` = {a_f, b_f} against `prev` every cycle:
  - `cur` == `prev` → no action.
  - Up sequence 00→10→11→01→00 (A leads B) → `step`=1, `mode`←1.
  - Down sequence 00→01→11→10→00 → `step`=1, `mode`←0.
  - Both bits changed (00↔11, 10↔01) → `err`=1; `err_cnt` increments, saturating at 2^ERR_W−1; no step; `mode` unchanged.
  - `prev` ← `cur` in all cases, including error.
- **`mode`** holds its value between steps. It changes only in the same cycle as a `step` pulse.
- **`clr_err`:**
  - Sets `err_cnt` to 0 on the next edge.
  - If an error occurs in the same cycle, clear wins (`err_cnt`=0) but `err` still pulses.
  - No effect on any other state.
- **Reset values:**
  - `step`=0, `err`=0, `mode`=1, `err_cnt`=0.
  - Synchronizers, filter state and `prev` = 0; priming restarts.
  - Reset asserted mid-operation aborts any pending filter qualification immediately.

## Timing

- Filter off: an input change sampled at edge k appears in `a_s` after edge k+1. `step`/`err` are registered and go high for exactly one cycle after edge k+2 (latency 3 clocks from the first sampling edge).
- Filter on: latency is 3 + FILT_LEN clocks.
- `step`, `mode` and `err` are registered outputs. `mode` is valid in the same cycle as `step`, so the downstream counter uses both on the same edge.
- Maximum legal edge rate: one accepted edge per cycle. Edges closer together than the filter window are rejected when the filter is enabled.
- `err_cnt` updates one edge after the `err`-causing sample. Its value is visible in the same cycle `err` is high.

## Configuration

- Macro: `QUAD_GLITCH_FILTER_EN`.
- **Defined:** each channel has a 4-bit run counter.
  - The counter increments while `x_s` != `x_f` and clears whenever `x_s` == `x_f`.
  - When it reaches FILT_LEN, `x_f` ← `x_s` and the counter clears.
  - A pulse shorter than FILT_LEN cycles never reaches the decoder.
- **Undefined:** `x_f` = `x_s` combinationally. The counters are not built and `FILT_LEN` is ignored.

## Test plan

- **Reset state:** assert `rst` with `a_in`/`b_in` = 11, release, hold inputs.
  - Expect `mode`=1, `step`=0, `err`=0 and `err_cnt`=0 throughout.
  - Expect no spurious error from priming.
- **Up sequence:** drive AB 00→10→11→01→00, each held 10 cycles, filter off.
  - Expect 4 `step` pulses, `mode`=1, each pulse 3 clocks after the input change.
- **Down and reversal:** drive AB 00→01→11, then 11→01.
  - Expect 2 steps with `mode`=0, then 1 step with `mode`=1.
- **Illegal transitions:** drive AB 00→11, then 11→00.
  - Expect 2 `err` pulses, `err_cnt`=2, no steps.
  - Pulse `clr_err` in the same cycle as a third error: expect `err`=1 and `err_cnt`=0.
- **Saturation:** with ERR_W=2, inject 5 illegal transitions.
  - Expect `err_cnt` to stop at 3 and `err` to pulse 5 times.
- **Filter (QUAD_GLITCH_FILTER_EN, FILT_LEN=3):**
  - A 2-cycle glitch on A → no step.
  - A 3-cycle-stable change → one step after 6 clocks.
  - `rst` asserted during qualification → all outputs return to reset values immediately.
